// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit: datapath widths,
// the default reset address and the fetch-control state encoding.
package ifetch_pkg;

    localparam int XLEN       = 32;
    localparam int INST_BYTES = 4;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    // Sequential fetch address; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] cur_pc);
        return cur_pc + XLEN'(INST_BYTES);
    endfunction

endpackage

// File: rtl/ifetch_buf.sv
// Two-entry instruction/pc FIFO between the memory response and decode.
// Flush has priority over push and pop. The head outputs read as zero while
// the FIFO is empty.
module ifetch_buf
    import ifetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push,
    input  logic [XLEN-1:0] push_inst,
    input  logic [XLEN-1:0] push_pc,
    input  logic            pop,
    output logic            valid,
    output logic [XLEN-1:0] head_inst,
    output logic [XLEN-1:0] head_pc,
    output logic [1:0]      count
);

    logic [XLEN-1:0] inst_q [2];
    logic [XLEN-1:0] pc_q   [2];
    logic            rd_ptr;
    logic            wr_ptr;
    logic            do_push;
    logic            do_pop;
    logic [1:0]      count_next;

    // Qualify push/pop against occupancy and compute the next count.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        do_push    = 1'b0;
        do_pop     = 1'b0;
        count_next = count;
        do_pop     = pop && (count != 2'd0);
        do_push    = push && ((count != 2'd2) || do_pop);
        count_next = count + {1'b0, do_push} - {1'b0, do_pop};
    end

    // Pointer and occupancy bookkeeping; reset and flush both empty the FIFO.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (rst || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count_next;
        end
    end

    // Entry storage; contents are only visible through a valid count.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the count guards every read, and the head is zero-gated.
        if (do_push) begin
            inst_q[wr_ptr] <= push_inst;
            pc_q[wr_ptr]   <= push_pc;
        end
    end

    assign valid     = (count != 2'd0);
    assign head_inst = valid ? inst_q[rd_ptr] : '0;
    assign head_pc   = valid ? pc_q[rd_ptr]   : '0;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: issues sequential word fetches to a memory with
// one cycle of read latency, buffers responses in a two-entry FIFO and
// handles redirects. Optional macro IFETCH_MISALIGN_EN adds the sticky
// misalign output and halts fetch on a misaligned redirect target; without
// it the target's low two bits are ignored.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] inst_in,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_inst,
    output logic [XLEN-1:0] if_pc
`ifdef IFETCH_MISALIGN_EN
    ,
    output logic            misalign
`endif
);

    fetch_state_t    state;
    logic            inflight;
    logic [XLEN-1:0] req_pc;
    logic [1:0]      buf_count;
    logic            pop;
    logic            issue;
    logic [2:0]      occupancy;
    logic [XLEN-1:0] target;
    logic            target_misaligned;

    // Redirect target decode; the low bits either flag a fault or are dropped.
`ifdef IFETCH_MISALIGN_EN
    assign target            = redirect_pc;
    assign target_misaligned = |redirect_pc[1:0];
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign target               = {redirect_pc[XLEN-1:2], 2'b00};
    assign target_misaligned    = 1'b0;
`endif

    // Issue only if the FIFO can still take this request's response after
    // this cycle's push/pop settle, so a response never finds the FIFO full.
    always_comb begin
        pop       = if_valid & if_ready;
        occupancy = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
        issue     = (state == ST_RUN) && !redirect_valid && (occupancy <= 3'd1);
    end

    // Fetch control FSM: owns pc, the inflight request and the misalign flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_BOOT;
            pc       <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
`ifdef IFETCH_MISALIGN_EN
            misalign <= 1'b0;
`endif
        end else if (redirect_valid) begin
            // Any response still in flight belongs to the old path: drop it.
            pc       <= target;
            inflight <= 1'b0;
            state    <= target_misaligned ? ST_HALT : ST_RUN;
`ifdef IFETCH_MISALIGN_EN
            misalign <= target_misaligned;
`endif
        end else begin
            case (state)
                ST_BOOT: begin
                    inflight <= 1'b0;
                    state    <= ST_RUN;
                end
                ST_RUN: begin
                    if (issue) begin
                        inflight <= 1'b1;
                        req_pc   <= pc;
                        pc       <= next_pc(pc);
                    end else begin
                        inflight <= 1'b0;
                    end
                end
                ST_HALT: begin
                    inflight <= 1'b0;
                end
                default: begin
                    state    <= ST_BOOT;
                    inflight <= 1'b0;
                end
            endcase
        end
    end

    ifetch_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (inflight),
        .push_inst (inst_in),
        .push_pc   (req_pc),
        .pop       (pop),
        .valid     (if_valid),
        .head_inst (if_inst),
        .head_pc   (if_pc),
        .count     (buf_count)
    );

endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch. A behavioural instruction memory
// returns the word for pc one cycle later. Outputs are sampled 1 time unit
// after each rising edge, and inputs are changed at that same point.
// Define IFETCH_MISALIGN_EN for both RTL and bench to cover the misalign path.
`timescale 1ns/1ps
module tb_ifetch;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] inst_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
`ifdef IFETCH_MISALIGN_EN
    logic        misalign;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_inst [4] = '{32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'hDDDD_DDDD};

    ifetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .inst_in        (inst_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_inst        (if_inst),
        .if_pc          (if_pc)
`ifdef IFETCH_MISALIGN_EN
        ,
        .misalign       (misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'hAAAA_AAAA;
            32'h0000_0004: return 32'hBBBB_BBBB;
            32'h0000_0008: return 32'hCCCC_CCCC;
            32'h0000_000C: return 32'hDDDD_DDDD;
            32'hFFFF_FFFC: return 32'h1234_5678;
            default:       return 32'h0BAD_0BAD;
        endcase
    endfunction

    // One-cycle-latency instruction memory.
    initial inst_in = 32'h0;
    always @(posedge clk) inst_in <= mem_word(pc);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b1;

        // Reset state
        step();
        step();
        check("rst_pc",      pc, 32'h0);
        check("rst_valid",   {31'b0, if_valid}, 32'h0);
        check("rst_if_inst", if_inst, 32'h0);
        check("rst_if_pc",   if_pc, 32'h0);
`ifdef IFETCH_MISALIGN_EN
        check("rst_misalign", {31'b0, misalign}, 32'h0);
`endif

        // Streaming with if_ready=1: boot cycle, then one instruction per cycle
        rst = 1'b0;
        step();
        check("boot_pc",    pc, 32'h0);
        check("boot_valid", {31'b0, if_valid}, 32'h0);
        step();
        check("first_issue_pc", pc, 32'h4);
        check("first_issue_valid", {31'b0, if_valid}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("stream_valid", {31'b0, if_valid}, 32'h1);
            check("stream_inst",  if_inst, exp_inst[i]);
            check("stream_pc",    if_pc, 32'(i * 4));
        end

        // Back-pressure: if_ready=0 for 5 cycles after first if_valid
        rst      = 1'b1;
        if_ready = 1'b0;
        step();
        rst = 1'b0;
        step();
        step();
        step();
        check("bp_first_valid", {31'b0, if_valid}, 32'h1);
        check("bp_first_if_pc", if_pc, 32'h0);
        check("bp_first_pc",    pc, 32'h8);
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_hold_if_pc", if_pc, 32'h0);
            check("bp_hold_inst",  if_inst, 32'hAAAA_AAAA);
            check("bp_hold_pc",    pc, 32'h8);
        end
        if_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            check("bp_release_valid", {31'b0, if_valid}, 32'h1);
            check("bp_release_if_pc", if_pc, 32'(i * 4));
            check("bp_release_inst",  if_inst, exp_inst[i]);
        end

        // Redirect to 8 while 0 and 4 are buffered
        rst      = 1'b1;
        if_ready = 1'b0;
        step();
        rst = 1'b0;
        step();
        step();
        step();
        step();
        check("rd8_pre_if_pc", if_pc, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8;
        step();
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        check("rd8_flush_valid", {31'b0, if_valid}, 32'h0);
        check("rd8_pc",          pc, 32'h8);
        step();
        check("rd8_wait_valid", {31'b0, if_valid}, 32'h0);
        step();
        check("rd8_valid", {31'b0, if_valid}, 32'h1);
        check("rd8_if_pc", if_pc, 32'h8);
        check("rd8_inst",  if_inst, 32'hCCCC_CCCC);

        // Redirect to the top word: pc wraps to 0
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("wrap_flush_valid", {31'b0, if_valid}, 32'h0);
        check("wrap_pc_top",      pc, 32'hFFFF_FFFC);
        step();
        check("wrap_pc_zero", pc, 32'h0);
        step();
        check("wrap_valid",    {31'b0, if_valid}, 32'h1);
        check("wrap_if_pc_hi", if_pc, 32'hFFFF_FFFC);
        check("wrap_inst_hi",  if_inst, 32'h1234_5678);
        step();
        check("wrap_if_pc_lo", if_pc, 32'h0);
        check("wrap_inst_lo",  if_inst, 32'hAAAA_AAAA);

        // Fill the FIFO, then pulse reset
        if_ready = 1'b0;
        step();
        step();
        step();
        check("full_hold_if_pc", if_pc, 32'h0);
        rst = 1'b1;
        step();
        rst      = 1'b0;
        if_ready = 1'b1;
        check("rst_mid_valid",   {31'b0, if_valid}, 32'h0);
        check("rst_mid_pc",      pc, 32'h0);
        check("rst_mid_if_inst", if_inst, 32'h0);
        step();
        step();
        step();
        check("rst_restart_if_pc", if_pc, 32'h0);
        check("rst_restart_inst",  if_inst, 32'hAAAA_AAAA);

        // Redirect with FIFO empty and nothing in flight
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        redirect_valid = 1'b1;
`ifdef IFETCH_MISALIGN_EN
        redirect_pc = 32'h4;
`else
        redirect_pc = 32'h6;  // low bits ignored in this build: target is 4
`endif
        step();
        redirect_valid = 1'b0;
        check("idle_rd_valid", {31'b0, if_valid}, 32'h0);
        check("idle_rd_pc",    pc, 32'h4);
        step();
        check("idle_rd_valid2", {31'b0, if_valid}, 32'h0);
        check("idle_rd_pc2",    pc, 32'h8);
        step();
        check("idle_rd_if_pc", if_pc, 32'h4);
        check("idle_rd_inst",  if_inst, 32'hBBBB_BBBB);

`ifdef IFETCH_MISALIGN_EN
        // Misaligned redirect halts fetch; aligned redirect resumes
        redirect_valid = 1'b1;
        redirect_pc    = 32'h6;
        step();
        redirect_valid = 1'b0;
        check("mis_flag",  {31'b0, misalign}, 32'h1);
        check("mis_valid", {31'b0, if_valid}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mis_hold_flag",  {31'b0, misalign}, 32'h1);
            check("mis_hold_valid", {31'b0, if_valid}, 32'h0);
            check("mis_hold_pc",    pc, 32'h6);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4;
        step();
        redirect_valid = 1'b0;
        check("mis_clear_flag",  {31'b0, misalign}, 32'h0);
        check("mis_clear_valid", {31'b0, if_valid}, 32'h0);
        step();
        step();
        check("mis_resume_valid", {31'b0, if_valid}, 32'h1);
        check("mis_resume_if_pc", if_pc, 32'h4);
        check("mis_resume_inst",  if_inst, 32'hBBBB_BBBB);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
